// File: rtl/dds_pdm_pkg.sv
// Shared constants and helpers for the DDS/PDM channel bank.
// Holds the mode and register codes, the sine table generator and a width helper.
package dds_pdm_pkg;

  typedef enum logic [2:0] {
    MODE_SAW_DN = 3'd0,
    MODE_SAW_UP = 3'd1,
    MODE_TRI    = 3'd2,
    MODE_SQUARE = 3'd3,
    MODE_SINE   = 3'd4,
    MODE_DC     = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ADDR_INC   = 2'd0,
    ADDR_MODE  = 2'd1,
    ADDR_AMP   = 2'd2,
    ADDR_PHASE = 2'd3
  } addr_e;

  function automatic int clog2(int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Offset sine sample for table entry idx: mid-scale + (mid-scale-1)*sin(2*pi*idx/2**aw).
  // Evaluated with a fixed-point Taylor series so the table is a pure elaboration constant.
  function automatic int sine_entry(int idx, int aw, int nb);
    longint s, pi_s, x, term, acc, n_ent;
    int half;
    s     = 64'sd1 << 24;
    pi_s  = 64'sd52707179;
    n_ent = 64'sd1 << aw;
    x     = (64'sd2 * pi_s * longint'(idx)) / n_ent;
    if (x > pi_s) x = x - 64'sd2 * pi_s;
    term = x;
    acc  = x;
    for (int k = 1; k < 8; k++) begin
      term = -((((term * x) / s) * x) / s) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    half = 1 << (nb - 1);
    return half + int'((longint'(half - 1) * acc) / s);
  endfunction

endpackage

// File: rtl/dds_pdm_bank_if.sv
// Register write port for the DDS/PDM bank, typically fed from the SPI slave.
interface dds_pdm_bank_if #(
  parameter int CH_W  = 3,
  parameter int ACC_W = 24
);
  logic             we;
  logic [CH_W-1:0]  ch;
  logic [1:0]       addr;
  logic [ACC_W-1:0] wdata;

  modport master (output we, ch, addr, wdata);
  modport slave  (input  we, ch, addr, wdata);
endinterface

// File: rtl/pdm_core.sv
// First-order PDM modulator: the carry of an error accumulator is the output bit.
module pdm_core #(
  parameter int NBITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] din,
  output logic             dout
);
  logic [NBITS-1:0] err;
  logic [NBITS:0]   sum;

  assign sum = {1'b0, err} + {1'b0, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= '0;
      dout <= 1'b0;
    end else begin
      dout <= sum[NBITS];
      err  <= sum[NBITS-1:0];
    end
  end
endmodule

// File: rtl/dds_pdm_bank.sv
// Multi-channel DDS waveform generator with a PDM output per channel.
// Each channel: phase accumulator -> wave register -> amplitude-scaled sample -> PDM.
module dds_pdm_bank
  import dds_pdm_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int NBITS  = 10,
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int CH_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  dds_pdm_bank_if.slave        cfg,
  output logic [NCH*NBITS-1:0] sample,
  output logic [NCH-1:0]       pdm_out,
  output logic [NCH-1:0]       wrap
);
  localparam logic [NBITS-1:0] MAX = '1;
  localparam int PW = 2 * NBITS + 1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] phase;
    logic [2:0]       mode;
    logic [NBITS-1:0] amp;
    logic [NBITS-1:0] wave;
    logic [NBITS-1:0] wave_nxt;
    logic [NBITS-1:0] smp;
    logic [NBITS-1:0] scaled;
    logic [NBITS-1:0] top;
    logic [NBITS-1:0] lower;
    logic [PW-1:0]    prod;
    logic [ACC_W:0]   acc_sum;
    logic             wrap_r;
    logic             hit;
    logic [NBITS-1:0] rom [2**LUT_AW];

    // Private copy of the sine table so every channel has its own read port.
    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
      assign rom[i] = NBITS'(sine_entry(i, LUT_AW, NBITS));
    end

    assign hit     = cfg.we && (cfg.ch == CH_W'(k));
    assign acc_sum = {1'b0, phase} + {1'b0, inc};
    assign top     = phase[ACC_W-1 -: NBITS];
    assign lower   = phase[ACC_W-2 -: NBITS];
    assign prod    = PW'(wave) * (PW'(amp) + PW'(1));
    assign scaled  = NBITS'(prod >> NBITS);

    always_comb begin
      wave_nxt = '0;
      case (mode)
        MODE_SAW_DN: wave_nxt = MAX - top;
        MODE_SAW_UP: wave_nxt = top;
        MODE_TRI:    wave_nxt = phase[ACC_W-1] ? ~lower : lower;
        MODE_SQUARE: wave_nxt = phase[ACC_W-1] ? '0 : MAX;
        MODE_SINE:   wave_nxt = rom[phase[ACC_W-1 -: LUT_AW]];
        MODE_DC:     wave_nxt = MAX;
        default:     wave_nxt = '0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inc    <= '0;
        mode   <= MODE_SAW_DN;
        amp    <= MAX;
        phase  <= '0;
        wrap_r <= 1'b0;
        wave   <= '0;
        smp    <= '0;
      end else begin
        if (hit && cfg.addr == ADDR_INC)  inc  <= cfg.wdata;
        if (hit && cfg.addr == ADDR_MODE) mode <= cfg.wdata[2:0];
        if (hit && cfg.addr == ADDR_AMP)  amp  <= cfg.wdata[NBITS-1:0];
        // A phase load overrides accumulation and never reports a wrap.
        if (hit && cfg.addr == ADDR_PHASE) begin
          phase  <= cfg.wdata;
          wrap_r <= 1'b0;
        end else if (en) begin
          phase  <= acc_sum[ACC_W-1:0];
          wrap_r <= acc_sum[ACC_W];
        end else begin
          wrap_r <= 1'b0;
        end
        wave <= wave_nxt;
        smp  <= scaled;
      end
    end

    assign sample[k*NBITS +: NBITS] = smp;
    assign wrap[k] = wrap_r;

    pdm_core #(.NBITS(NBITS)) u_pdm (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (smp),
      .dout  (pdm_out[k])
    );
  end
endmodule
